// File: rtl/ay_port_seq.sv
// ay_port_seq: turns AY-3-8910 register read/write requests into BK-0011M XT5 port transactions.
// Latency: acceptance edge to rsp_valid is 2*(SETUP_CYC+STB_CYC+HOLD_CYC)+1 cycles, or half+1 on an address-cache hit.
// Backpressure: req_ready is high only while idle; req_valid is ignored while busy and must be held until accepted.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake; req_rd, req_addr, req_wdata captured on acceptance
//   rsp_valid, rsp_rdata      one-cycle completion pulse, read result (held between reads)
//   XT5_out_pin, XT5_in_pin   inverted port data pins (upper output byte always 8'hFF)
//   nSEL2, STROBE, DOUT, nWRTBT, busy   port control lines and activity flag
// Optional feature: define AY_ADDR_CACHE_EN to skip the address phase when the AY
// register number matches the one latched by the previous address phase.
//
// All outputs come from flops loaded with the decode of the current state, so
// the pins trail the internal state by one cycle. req_ready is the exception:
// it is loaded from the next state so that it drops on the acceptance edge.

module ay_port_seq #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned STB_CYC   = 4,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rd,
    input  logic [3:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] XT5_out_pin,
    input  logic [15:0] XT5_in_pin,
    output logic        nSEL2,
    output logic        STROBE,
    output logic        DOUT,
    output logic        nWRTBT,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STB,
        ST_A_HOLD,
        ST_X_SETUP,
        ST_X_STB,
        ST_X_HOLD
    } state_t;

    // Down-counter reload values: a state lasting N cycles is entered with N-1.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STB_LD   = 4'(STB_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        rd_q, rd_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        fin_q, fin_d;          // state just entered IDLE from X_HOLD
    logic        cap_q, cap_d;          // pins are showing the last X_STB cycle of a read
    logic [15:0] pins_q, pins_d;
    logic        nsel2_q, nsel2_d;
    logic        strobe_q, strobe_d;
    logic        dout_q, dout_d;
    logic        nwrtbt_q, nwrtbt_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        phase_done;
    logic        cache_hit;
    logic [7:0]  in_hi_unused;

    assign accept       = req_valid && req_ready_q;
    assign phase_done   = (cnt_q == 4'd0);
    assign in_hi_unused = XT5_in_pin[15:8];

`ifdef AY_ADDR_CACHE_EN
    logic [3:0] last_addr_q, last_addr_d;
    logic       cache_vld_q, cache_vld_d;

    // The AY keeps its latched register number until the next LADDR, so the
    // cache only records addresses whose address phase actually completed.
    always_comb begin
        last_addr_d = last_addr_q;
        cache_vld_d = cache_vld_q;
        if (state_q == ST_A_HOLD && phase_done) begin
            last_addr_d = addr_q;
            cache_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr_q <= 4'h0;
            cache_vld_q <= 1'b0;
        end else begin
            last_addr_q <= last_addr_d;
            cache_vld_q <= cache_vld_d;
        end
    end

    assign cache_hit = cache_vld_q && (req_addr == last_addr_q);
`else
    assign cache_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = cache_hit ? ST_X_SETUP : ST_A_SETUP;
            ST_A_SETUP: if (phase_done) state_d = ST_A_STB;
            ST_A_STB:   if (phase_done) state_d = ST_A_HOLD;
            ST_A_HOLD:  if (phase_done) state_d = ST_X_SETUP;
            ST_X_SETUP: if (phase_done) state_d = ST_X_STB;
            ST_X_STB:   if (phase_done) state_d = ST_X_HOLD;
            ST_X_HOLD:  if (phase_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                ST_A_SETUP, ST_X_SETUP: cnt_d = SETUP_LD;
                ST_A_STB,   ST_X_STB:   cnt_d = STB_LD;
                ST_A_HOLD,  ST_X_HOLD:  cnt_d = HOLD_LD;
                default:                cnt_d = 4'h0;
            endcase
        end else if (!phase_done) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Output decode; the result is registered below
    always_comb begin
        pins_d   = 16'hFFFF;
        nsel2_d  = 1'b1;
        strobe_d = 1'b0;
        dout_d   = 1'b1;
        nwrtbt_d = 1'b1;
        busy_d   = 1'b0;
        case (state_q)
            ST_A_SETUP, ST_A_STB, ST_A_HOLD: begin
                pins_d   = {8'hFF, ~{4'h0, addr_q}};
                nsel2_d  = 1'b0;
                nwrtbt_d = 1'b0;
                busy_d   = 1'b1;
                strobe_d = (state_q == ST_A_STB);
            end
            ST_X_SETUP, ST_X_STB, ST_X_HOLD: begin
                nsel2_d  = 1'b0;
                busy_d   = 1'b1;
                strobe_d = (state_q == ST_X_STB);
                if (rd_q) begin
                    dout_d = 1'b0;   // pins stay released so the AY can drive them
                end else begin
                    pins_d = {8'hFF, ~wdata_q};
                end
            end
            default: ;
        endcase

        fin_d       = (state_q == ST_X_HOLD) && phase_done;
        cap_d       = (state_q == ST_X_STB) && phase_done && rd_q;
        rsp_valid_d = fin_q;
        // Sampled at the end of the last strobe cycle seen on the pins.
        rsp_rdata_d = cap_q ? ~XT5_in_pin[7:0] : rsp_rdata_q;
        req_ready_d = (state_d == ST_IDLE);
    end

    // Request capture
    always_comb begin
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            rd_d    = req_rd;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q        <= 1'b0;
            addr_q      <= 4'h0;
            wdata_q     <= 8'h00;
            req_ready_q <= 1'b1;
            fin_q       <= 1'b0;
            cap_q       <= 1'b0;
            pins_q      <= 16'hFFFF;
            nsel2_q     <= 1'b1;
            strobe_q    <= 1'b0;
            dout_q      <= 1'b1;
            nwrtbt_q    <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            fin_q       <= fin_d;
            cap_q       <= cap_d;
            pins_q      <= pins_d;
            nsel2_q     <= nsel2_d;
            strobe_q    <= strobe_d;
            dout_q      <= dout_d;
            nwrtbt_q    <= nwrtbt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign XT5_out_pin = pins_q;
    assign nSEL2       = nsel2_q;
    assign STROBE      = strobe_q;
    assign DOUT        = dout_q;
    assign nWRTBT      = nwrtbt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ay_port_seq.sv
// Directed bench for ay_port_seq: default-timing instance plus a 1/1/1 timing instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values depend on whether AY_ADDR_CACHE_EN is defined for the build.

module tb_ay_port_seq;

`ifdef AY_ADDR_CACHE_EN
    localparam int HIT_LAT   = 9;
    localparam int HIT_STB_A = 0;
    localparam int HELD_RSP3 = 44;
`else
    localparam int HIT_LAT   = 17;
    localparam int HIT_STB_A = 4;
    localparam int HELD_RSP3 = 52;
`endif

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_rd;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [15:0] xt5_out, xt5_in;
    logic        nsel2, strobe, dout, nwrtbt, busy;

    logic        m_req_valid, m_req_ready, m_req_rd;
    logic [3:0]  m_req_addr;
    logic [7:0]  m_req_wdata;
    logic        m_rsp_valid;
    logic [7:0]  m_rsp_rdata;
    logic [15:0] m_xt5_out, m_xt5_in;
    logic        m_nsel2, m_strobe, m_dout, m_nwrtbt, m_busy;

    int n_cmp = 0;
    int n_err = 0;

    ay_port_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .XT5_out_pin(xt5_out), .XT5_in_pin(xt5_in),
        .nSEL2(nsel2), .STROBE(strobe), .DOUT(dout), .nWRTBT(nwrtbt), .busy(busy)
    );

    ay_port_seq #(.SETUP_CYC(1), .STB_CYC(1), .HOLD_CYC(1)) dut_min (
        .clk(clk), .rst(rst),
        .req_valid(m_req_valid), .req_ready(m_req_ready), .req_rd(m_req_rd),
        .req_addr(m_req_addr), .req_wdata(m_req_wdata),
        .rsp_valid(m_rsp_valid), .rsp_rdata(m_rsp_rdata),
        .XT5_out_pin(m_xt5_out), .XT5_in_pin(m_xt5_in),
        .nSEL2(m_nsel2), .STROBE(m_strobe), .DOUT(m_dout), .nWRTBT(m_nwrtbt), .busy(m_busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Issues one request on the default instance and records what the pins did.
    // k counts falling edges after the acceptance edge (k=0 is just after it).
    task automatic run_txn(input logic rd, input logic [3:0] a, input logic [7:0] d,
                           output int lat, output int rdy_k, output int stb_a, output int stb_x,
                           output logic [15:0] pin_a, output logic [15:0] pin_x,
                           output int dout0, output int rv, output logic [7:0] rdata,
                           output int chg);
        logic        prev_stb;
        logic [15:0] prev_pin;
        int          w;
        lat = -1; rdy_k = -1; stb_a = 0; stb_x = 0; dout0 = 0; rv = 0; chg = 0;
        pin_a = 16'hxxxx; pin_x = 16'hxxxx; rdata = 8'hxx;
        prev_stb = 1'b0; prev_pin = 16'hFFFF;
        req_rd = rd; req_addr = a; req_wdata = d; req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (strobe === 1'b1) begin
                if (prev_stb && xt5_out !== prev_pin) chg++;
                if (nwrtbt === 1'b0) begin stb_a++; pin_a = xt5_out; end
                else begin stb_x++; pin_x = xt5_out; if (dout === 1'b0) dout0++; end
            end
            prev_stb = (strobe === 1'b1);
            prev_pin = xt5_out;
            if (rdy_k < 0 && req_ready === 1'b1) rdy_k = k;
            if (rsp_valid === 1'b1) begin
                rv++;
                if (lat < 0) begin lat = k; rdata = rsp_rdata; end
            end
            if (lat >= 0 && k >= lat + 2) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; m_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (xt5_out !== 16'hFFFF) begin n_err++; $display("FAIL rst_pins: got %h want ffff", xt5_out); end
        n_cmp++; if (nsel2 !== 1'b1) begin n_err++; $display("FAIL rst_nsel2: got %b want 1", nsel2); end
        n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL rst_strobe: got %b want 0", strobe); end
        n_cmp++; if (dout !== 1'b1) begin n_err++; $display("FAIL rst_dout: got %b want 1", dout); end
        n_cmp++; if (nwrtbt !== 1'b1) begin n_err++; $display("FAIL rst_nwrtbt: got %b want 1", nwrtbt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", rsp_rdata); end
        n_cmp++; if (m_xt5_out !== 16'hFFFF) begin n_err++; $display("FAIL rst_min_pins: got %h want ffff", m_xt5_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int lat, rdy_k, sa, sx, d0, rv, chg;
        logic [15:0] pa, px;
        logic [7:0]  rd;
        run_txn(1'b0, 4'd7, 8'h3E, lat, rdy_k, sa, sx, pa, px, d0, rv, rd, chg);
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL wr_latency: got %0d want 17", lat); end
        n_cmp++; if (sa !== 4) begin n_err++; $display("FAIL wr_addr_strobe_len: got %0d want 4", sa); end
        n_cmp++; if (sx !== 4) begin n_err++; $display("FAIL wr_data_strobe_len: got %0d want 4", sx); end
        n_cmp++; if (pa !== 16'hFFF8) begin n_err++; $display("FAIL wr_addr_pins: got %h want fff8", pa); end
        n_cmp++; if (px !== 16'hFFC1) begin n_err++; $display("FAIL wr_data_pins: got %h want ffc1", px); end
        n_cmp++; if (d0 !== 0) begin n_err++; $display("FAIL wr_dout_low_cycles: got %0d want 0", d0); end
        n_cmp++; if (rv !== 1) begin n_err++; $display("FAIL wr_rsp_pulses: got %0d want 1", rv); end
        n_cmp++; if (rdy_k !== 16) begin n_err++; $display("FAIL wr_ready_rise: got %0d want 16", rdy_k); end
        n_cmp++; if (chg !== 0) begin n_err++; $display("FAIL wr_pins_change_in_strobe: got %0d want 0", chg); end
    endtask

    task automatic test_read();
        int lat, rdy_k, sa, sx, d0, rv, chg;
        logic [15:0] pa, px;
        logic [7:0]  rd;
        xt5_in = ~16'h00A5;
        run_txn(1'b1, 4'd14, 8'h00, lat, rdy_k, sa, sx, pa, px, d0, rv, rd, chg);
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL rd_latency: got %0d want 17", lat); end
        n_cmp++; if (pa !== 16'hFFF1) begin n_err++; $display("FAIL rd_addr_pins: got %h want fff1", pa); end
        n_cmp++; if (px !== 16'hFFFF) begin n_err++; $display("FAIL rd_released_pins: got %h want ffff", px); end
        n_cmp++; if (d0 !== 4) begin n_err++; $display("FAIL rd_dout_low_cycles: got %0d want 4", d0); end
        n_cmp++; if (rd !== 8'hA5) begin n_err++; $display("FAIL rd_rdata: got %h want a5", rd); end
        n_cmp++; if (rv !== 1) begin n_err++; $display("FAIL rd_rsp_pulses: got %0d want 1", rv); end
        n_cmp++; if (rsp_rdata !== 8'hA5) begin n_err++; $display("FAIL rd_rdata_hold: got %h want a5", rsp_rdata); end
        xt5_in = 16'hFFFF;
    endtask

    task automatic test_addr_cache();
        int lat, rdy_k, sa, sx, d0, rv, chg;
        logic [15:0] pa, px;
        logic [7:0]  rd;
        run_txn(1'b0, 4'd8, 8'h0F, lat, rdy_k, sa, sx, pa, px, d0, rv, rd, chg);
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL cache_first_latency: got %0d want 17", lat); end
        n_cmp++; if (px !== 16'hFFF0) begin n_err++; $display("FAIL cache_first_data: got %h want fff0", px); end
        run_txn(1'b0, 4'd8, 8'h10, lat, rdy_k, sa, sx, pa, px, d0, rv, rd, chg);
        n_cmp++; if (lat !== HIT_LAT) begin n_err++; $display("FAIL cache_second_latency: got %0d want %0d", lat, HIT_LAT); end
        n_cmp++; if (sa !== HIT_STB_A) begin n_err++; $display("FAIL cache_second_addr_strobe: got %0d want %0d", sa, HIT_STB_A); end
        n_cmp++; if (px !== 16'hFFEF) begin n_err++; $display("FAIL cache_second_data: got %h want ffef", px); end
        n_cmp++; if (rdata_unchanged_check(rsp_rdata) !== 8'hA5) begin n_err++; $display("FAIL cache_rdata_kept: got %h want a5", rsp_rdata); end
    endtask

    function automatic logic [7:0] rdata_unchanged_check(input logic [7:0] v);
        return v;
    endfunction

    task automatic test_back_to_back();
        logic [3:0]  addrs [3];
        logic [7:0]  datas [3];
        logic [7:0]  xb [3];
        int          rsp_c [3];
        int          nacc, nr, nx, idle_cnt;
        logic        acc, prev_stb;
        addrs[0] = 4'd2; datas[0] = 8'h11;
        addrs[1] = 4'd3; datas[1] = 8'h22;
        addrs[2] = 4'd3; datas[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin xb[i] = 8'hxx; rsp_c[i] = -1; end
        nacc = 0; nr = 0; nx = 0; idle_cnt = 0; prev_stb = 1'b0;
        req_rd = 1'b0; req_addr = addrs[0]; req_wdata = datas[0]; req_valid = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (rsp_valid === 1'b1 && nr < 3) begin rsp_c[nr] = c; nr++; end
            if (strobe === 1'b1 && nwrtbt === 1'b1 && !prev_stb && nx < 3) begin xb[nx] = xt5_out[7:0]; nx++; end
            prev_stb = (strobe === 1'b1);
            if (c >= 2 && nr < 3 && nsel2 === 1'b1) idle_cnt++;
            acc = (req_valid === 1'b1) && (req_ready === 1'b1);
            @(negedge clk);
            if (acc) begin
                nacc++;
                if (nacc < 3) begin req_addr = addrs[nacc]; req_wdata = datas[nacc]; end
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (nacc !== 3) begin n_err++; $display("FAIL b2b_accepts: got %0d want 3", nacc); end
        n_cmp++; if (rsp_c[0] !== 18) begin n_err++; $display("FAIL b2b_rsp1_cycle: got %0d want 18", rsp_c[0]); end
        n_cmp++; if (rsp_c[1] !== 35) begin n_err++; $display("FAIL b2b_rsp2_cycle: got %0d want 35", rsp_c[1]); end
        n_cmp++; if (rsp_c[2] !== HELD_RSP3) begin n_err++; $display("FAIL b2b_rsp3_cycle: got %0d want %0d", rsp_c[2], HELD_RSP3); end
        n_cmp++; if (xb[0] !== 8'hEE) begin n_err++; $display("FAIL b2b_data1: got %h want ee", xb[0]); end
        n_cmp++; if (xb[1] !== 8'hDD) begin n_err++; $display("FAIL b2b_data2: got %h want dd", xb[1]); end
        n_cmp++; if (xb[2] !== 8'hCC) begin n_err++; $display("FAIL b2b_data3: got %h want cc", xb[2]); end
        n_cmp++; if (idle_cnt !== 2) begin n_err++; $display("FAIL b2b_idle_cycles: got %0d want 2", idle_cnt); end
    endtask

    task automatic test_reset_mid();
        int w, rv_cnt;
        int lat, rdy_k, sa, sx, d0, rv, chg;
        logic [15:0] pa, px;
        logic [7:0]  rd;
        req_rd = 1'b0; req_addr = 4'd5; req_wdata = 8'hAA; req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (!(strobe === 1'b1 && nwrtbt === 1'b0) && w < 40) begin @(negedge clk); w++; end
        n_cmp++; if (strobe !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_addr_strobe: got %b want 1", strobe); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (xt5_out !== 16'hFFFF) begin n_err++; $display("FAIL rstmid_pins: got %h want ffff", xt5_out); end
        n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL rstmid_strobe: got %b want 0", strobe); end
        n_cmp++; if (nsel2 !== 1'b1) begin n_err++; $display("FAIL rstmid_nsel2: got %b want 1", nsel2); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
        rst = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (rsp_valid === 1'b1) rv_cnt++;
            @(negedge clk);
        end
        n_cmp++; if (rv_cnt !== 0) begin n_err++; $display("FAIL rstmid_no_rsp: got %0d want 0", rv_cnt); end
        run_txn(1'b0, 4'd5, 8'hAA, lat, rdy_k, sa, sx, pa, px, d0, rv, rd, chg);
        n_cmp++; if (sa !== 4) begin n_err++; $display("FAIL rstmid_addr_phase_rerun: got %0d want 4", sa); end
        n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL rstmid_latency: got %0d want 17", lat); end
    endtask

    task automatic test_min_timing();
        int w, lat, rdy_k, sa, sx;
        logic [15:0] pa, px;
        lat = -1; rdy_k = -1; sa = 0; sx = 0; pa = 16'hxxxx; px = 16'hxxxx;
        m_req_rd = 1'b0; m_req_addr = 4'd0; m_req_wdata = 8'hFF; m_req_valid = 1'b1;
        w = 0;
        while (m_req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        m_req_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (m_strobe === 1'b1) begin
                if (m_nwrtbt === 1'b0) begin sa++; pa = m_xt5_out; end
                else begin sx++; px = m_xt5_out; end
            end
            if (rdy_k < 0 && m_req_ready === 1'b1) rdy_k = k;
            if (lat < 0 && m_rsp_valid === 1'b1) lat = k;
            if (lat >= 0 && k >= lat + 2) break;
            @(negedge clk);
        end
        n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL min_latency: got %0d want 7", lat); end
        n_cmp++; if (sa !== 1) begin n_err++; $display("FAIL min_addr_strobe_len: got %0d want 1", sa); end
        n_cmp++; if (sx !== 1) begin n_err++; $display("FAIL min_data_strobe_len: got %0d want 1", sx); end
        n_cmp++; if (pa !== 16'hFFFF) begin n_err++; $display("FAIL min_addr_pins: got %h want ffff", pa); end
        n_cmp++; if (px !== 16'hFF00) begin n_err++; $display("FAIL min_data_pins: got %h want ff00", px); end
        n_cmp++; if (rdy_k !== 6) begin n_err++; $display("FAIL min_ready_rise: got %0d want 6", rdy_k); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_rd = 1'b0; req_addr = 4'h0; req_wdata = 8'h00; xt5_in = 16'hFFFF;
        m_req_valid = 1'b0; m_req_rd = 1'b0; m_req_addr = 4'h0; m_req_wdata = 8'h00; m_xt5_in = 16'hFFFF;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_addr_cache();
        test_back_to_back();
        test_reset_mid();
        test_min_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
